// File: rtl/k053260_pkg.sv
// k053260_pkg
// Shared widths, the 13-bit floating-point word layout and the
// word-to-PCM conversion used by the 053260 DAC stream receiver.
package k053260_pkg;

  localparam int WORD_W = 13;
  localparam int MANT_W = 10;
  localparam int EXP_W  = 3;
  localparam int PCM_W  = 16;

  // Bit order matches the serial word: D[12:10] exponent, D[9:0] mantissa.
  typedef struct packed {
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } k053260_word_t;

  // Mantissa is offset binary; flipping the MSB gives a signed 10-bit value.
  // Exponent 0 is silence, 1..7 scale by 2^(E-1). The largest shift (6)
  // keeps the result inside 16 bits, so no saturation is needed.
  function automatic logic [PCM_W-1:0] fp_to_pcm(input k053260_word_t w);
    logic [PCM_W-1:0] ext;
    ext = {{(PCM_W-MANT_W+1){~w.mant[MANT_W-1]}}, w.mant[MANT_W-2:0]};
    case (w.exp)
      3'd0:    return {PCM_W{1'b0}};
      default: return ext << (w.exp - 3'd1);
    endcase
  endfunction

endpackage

// File: rtl/k053260_fp_decode.sv
// k053260_fp_decode
// Registered decode stage for one channel: converts a latched 13-bit
// floating-point word to signed 16-bit PCM one clock after load.
// Ports:
//   clk   - system clock
//   rst   - asynchronous active-high reset
//   load  - word was latched on the previous clock; decode it now
//   word  - latched 13-bit word {exp[2:0], mant[9:0]}
//   pcm   - signed 16-bit sample (registered)
//   valid - one-clock pulse when pcm updates
module k053260_fp_decode
  import k053260_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WORD_W-1:0] word,
  output logic [PCM_W-1:0]  pcm,
  output logic              valid
);

  // Output register and valid pulse; a load every clock is sustained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcm   <= {PCM_W{1'b0}};
      valid <= 1'b0;
    end else begin
      valid <= load;
      if (load) begin
        pcm <= fp_to_pcm(k053260_word_t'(word));
      end
    end
  end

endmodule

// File: rtl/k053260_dac_rx.sv
// k053260_dac_rx
// Receiver for the 053260 serial DAC link (YM3012 side). SO is shifted in
// LSB first on SY rising edges; an SH1 falling edge latches the left word,
// an SH2 falling edge the right word. Each latched word is decoded to
// signed 16-bit PCM one clock later, with a one-clock VALID pulse.
// Optional build macro K053260_DAC_RX_FRAME_CHECK_EN adds a sticky
// FRAME_ERR flag for frames shorter than MIN_BITS SY rises; without it
// FRAME_ERR is tied low.
// Ports:
//   CLK       - system clock (SY runs at CLK/2, synchronous)
//   RES       - asynchronous active-high reset
//   SY        - serial bit clock
//   SH1, SH2  - left/right latch strobes, falling edge active
//   SO        - serial data, LSB first
//   L_OUT     - signed left sample      R_OUT   - signed right sample
//   L_VALID   - left update pulse       R_VALID - right update pulse
//   FRAME_ERR - sticky short-frame flag
module k053260_dac_rx
  import k053260_pkg::*;
#(
  parameter int SHIFT_LEN = 16,
  parameter int MIN_BITS  = 13
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        SY,
  input  logic        SH1,
  input  logic        SH2,
  input  logic        SO,
  output logic [15:0] L_OUT,
  output logic [15:0] R_OUT,
  output logic        L_VALID,
  output logic        R_VALID,
  output logic        FRAME_ERR
);

  if (SHIFT_LEN < WORD_W + 1 || MIN_BITS < 0 || MIN_BITS > 31) begin : g_cfg_check
    $error("k053260_dac_rx: unsupported SHIFT_LEN or MIN_BITS");
  end

  logic                 sy_d_r;
  logic                 sh1_d_r;
  logic                 sh2_d_r;
  logic [SHIFT_LEN-1:0] sr_r;
  logic [SHIFT_LEN-1:0] sr_next_s;
  k053260_word_t        word_s;
  k053260_word_t        raw_l_r;
  k053260_word_t        raw_r_r;
  logic                 ld_l_r;
  logic                 ld_r_r;
  logic                 sy_rise_s;
  logic                 sh1_fall_s;
  logic                 sh2_fall_s;
  logic                 unused_s;

  assign sy_rise_s  = ~sy_d_r & SY;
  assign sh1_fall_s = sh1_d_r & ~SH1;
  assign sh2_fall_s = sh2_d_r & ~SH2;

  // Next shift-register value; latches use it so a bit shifted in on the
  // same clock as a strobe edge is part of the latched word.
  always_comb begin
    sr_next_s = sr_r;
    if (sy_rise_s) begin
      sr_next_s = {SO, sr_r[SHIFT_LEN-1:1]};
    end else begin
      sr_next_s = sr_r;
    end
  end

  // The word is the 13 most recent bits, newest at the MSB.
  assign word_s = sr_next_s[SHIFT_LEN-1 -: WORD_W];

  // Older shift stages only provide depth; they never reach the decoder.
  assign unused_s = ^{sr_r[0], sr_next_s[SHIFT_LEN-WORD_W-1:0]};

  // Edge-detect history and the serial shift register.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      sy_d_r  <= 1'b0;
      sh1_d_r <= 1'b0;
      sh2_d_r <= 1'b0;
      sr_r    <= {SHIFT_LEN{1'b0}};
    end else begin
      sy_d_r  <= SY;
      sh1_d_r <= SH1;
      sh2_d_r <= SH2;
      sr_r    <= sr_next_s;
    end
  end

  // Raw word latches plus the load flags that launch the decode stage.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      raw_l_r <= k053260_word_t'({WORD_W{1'b0}});
      raw_r_r <= k053260_word_t'({WORD_W{1'b0}});
      ld_l_r  <= 1'b0;
      ld_r_r  <= 1'b0;
    end else begin
      ld_l_r <= sh1_fall_s;
      ld_r_r <= sh2_fall_s;
      if (sh1_fall_s) begin
        raw_l_r <= word_s;
      end
      if (sh2_fall_s) begin
        raw_r_r <= word_s;
      end
    end
  end

  k053260_fp_decode u_dec_l (
    .clk   (CLK),
    .rst   (RES),
    .load  (ld_l_r),
    .word  (raw_l_r),
    .pcm   (L_OUT),
    .valid (L_VALID)
  );

  k053260_fp_decode u_dec_r (
    .clk   (CLK),
    .rst   (RES),
    .load  (ld_r_r),
    .word  (raw_r_r),
    .pcm   (R_OUT),
    .valid (R_VALID)
  );

`ifdef K053260_DAC_RX_FRAME_CHECK_EN
  logic [4:0] bit_cnt_r;
  logic       frame_err_r;

  // Count SY rises since the last strobe; a short frame sets the sticky
  // flag. A rise coinciding with the strobe belongs to the next frame.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      bit_cnt_r   <= 5'd0;
      frame_err_r <= 1'b0;
    end else if (sh1_fall_s || sh2_fall_s) begin
      if (bit_cnt_r < 5'(MIN_BITS)) begin
        frame_err_r <= 1'b1;
      end
      bit_cnt_r <= sy_rise_s ? 5'd1 : 5'd0;
    end else if (sy_rise_s && (bit_cnt_r != 5'd31)) begin
      bit_cnt_r <= bit_cnt_r + 5'd1;
    end
  end

  assign FRAME_ERR = frame_err_r;
`else
  assign FRAME_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_k053260_dac_rx.sv
// tb_k053260_dac_rx
// Bench for k053260_dac_rx: directed frames from the test plan followed
// by randomized frames, checked against a bit-history reference model.
module tb_k053260_dac_rx;

  logic        CLK = 1'b0;
  logic        RES;
  logic        SY;
  logic        SH1;
  logic        SH2;
  logic        SO;
  logic [15:0] L_OUT;
  logic [15:0] R_OUT;
  logic        L_VALID;
  logic        R_VALID;
  logic        FRAME_ERR;

  k053260_dac_rx dut (
    .CLK       (CLK),
    .RES       (RES),
    .SY        (SY),
    .SH1       (SH1),
    .SH2       (SH2),
    .SO        (SO),
    .L_OUT     (L_OUT),
    .R_OUT     (R_OUT),
    .L_VALID   (L_VALID),
    .R_VALID   (R_VALID),
    .FRAME_ERR (FRAME_ERR)
  );

  always #5 CLK = ~CLK;

  int chk_cnt = 0;
  int err_cnt = 0;

  // Reference model: every bit received since reset, bits since last strobe,
  // the sticky error and the last sample delivered per channel.
  bit          hist[$];
  int          bits_since;
  bit          err_m;
  logic [15:0] exp_l;
  logic [15:0] exp_r;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // The word is the 13 most recent bits, newest bit at D[12]; bits never
  // received since reset read as zero.
  function automatic logic [12:0] model_word();
    logic [12:0] d;
    d = 13'd0;
    for (int i = 0; i < 13; i++) begin
      int idx;
      idx = hist.size() - 13 + i;
      d[i] = (idx >= 0) ? hist[idx] : 1'b0;
    end
    return d;
  endfunction

  // Offset-binary mantissa minus 512, scaled by 2^(E-1); E=0 is silence.
  function automatic logic [15:0] model_pcm(input logic [12:0] d);
    int mant;
    int e;
    int v;
    mant = int'(d[9:0]);
    e    = int'(d[12:10]);
    if (e == 0) v = 0;
    else        v = (mant - 512) * (1 << (e - 1));
    return v[15:0];
  endfunction

  function automatic logic exp_ferr();
`ifdef K053260_DAC_RX_FRAME_CHECK_EN
    return err_m;
`else
    return 1'b0;
`endif
  endfunction

  task automatic send_bit(input bit b);
    SO = b;
    SY = 1'b1;
    hist.push_back(b);
    bits_since++;
    @(posedge CLK); #1;
    SY = 1'b0;
    @(posedge CLK); #1;
  endtask

  // Strobe one or both channels, optionally together with a final SY rise,
  // then check the VALID timing and the decoded samples.
  task automatic do_latch(input bit l, input bit r, input bit coinc, input bit last_b);
    logic [12:0] d;
    if (coinc) begin
      SO = last_b;
      SY = 1'b1;
      hist.push_back(last_b);
    end
    d = model_word();
    if (bits_since < 13) err_m = 1'b1;
    bits_since = coinc ? 1 : 0;
    if (l) exp_l = model_pcm(d);
    if (r) exp_r = model_pcm(d);
    SH1 = ~l;
    SH2 = ~r;
    @(posedge CLK); #1;
    SY  = 1'b0;
    SH1 = 1'b1;
    SH2 = 1'b1;
    check_eq("l_valid_early", L_VALID, 1'b0);
    check_eq("r_valid_early", R_VALID, 1'b0);
    @(posedge CLK); #1;
    check_eq("l_valid", L_VALID, l);
    check_eq("r_valid", R_VALID, r);
    check_eq("l_out", L_OUT, exp_l);
    check_eq("r_out", R_OUT, exp_r);
    check_eq("frame_err", FRAME_ERR, exp_ferr());
    @(posedge CLK); #1;
    check_eq("l_valid_end", L_VALID, 1'b0);
    check_eq("r_valid_end", R_VALID, 1'b0);
  endtask

  // Send nbits with d as the final 13 (random filler before), then strobe.
  task automatic frame(input logic [12:0] d, input int nbits, input bit l, input bit r, input bit coinc);
    bit b;
    bit last_b;
    last_b = 1'b0;
    for (int k = 0; k < nbits; k++) begin
      if (nbits >= 13 && k >= nbits - 13) b = d[k - (nbits - 13)];
      else                                b = 1'($urandom_range(0, 1));
      if (coinc && k == nbits - 1) last_b = b;
      else                         send_bit(b);
    end
    do_latch(l, r, coinc, last_b);
  endtask

  task automatic reset_pulse();
    RES = 1'b1;
    #2;
    check_eq("rst_async", {L_OUT, R_OUT, L_VALID, R_VALID, FRAME_ERR}, 35'd0);
    @(posedge CLK); #1;
    check_eq("rst_hold", {L_OUT, R_OUT, L_VALID, R_VALID, FRAME_ERR}, 35'd0);
    RES = 1'b0;
    hist.delete();
    bits_since = 0;
    err_m = 1'b0;
    exp_l = 16'h0000;
    exp_r = 16'h0000;
    @(posedge CLK); #1;
  endtask

  initial begin
    int  nb;
    bit  l;
    bit  r;
    RES = 1'b1;
    SY  = 1'b0;
    SH1 = 1'b1;
    SH2 = 1'b1;
    SO  = 1'b0;
    bits_since = 0;
    err_m = 1'b0;
    exp_l = 16'h0000;
    exp_r = 16'h0000;
    repeat (3) @(posedge CLK);
    #1;
    check_eq("reset_state", {L_OUT, R_OUT, L_VALID, R_VALID, FRAME_ERR}, 35'd0);
    RES = 1'b0;
    @(posedge CLK); #1;

    // Directed frames with hand-computed results.
    frame({3'd1, 10'h3FF}, 16, 1'b1, 1'b0, 1'b0);
    check_eq("dir_e1_max_l", L_OUT, 16'h01FF);
    check_eq("dir_e1_r_idle", R_OUT, 16'h0000);
    frame({3'd7, 10'h000}, 16, 1'b0, 1'b1, 1'b0);
    check_eq("dir_e7_min", R_OUT, 16'h8000);
    frame({3'd7, 10'h3FF}, 16, 1'b0, 1'b1, 1'b0);
    check_eq("dir_e7_max", R_OUT, 16'h7FC0);
    frame({3'd0, 10'h2AA}, 16, 1'b1, 1'b0, 1'b0);
    check_eq("dir_e0_zero", L_OUT, 16'h0000);
    frame({3'd3, 10'h201}, 16, 1'b1, 1'b1, 1'b1);
    check_eq("dir_both_l", L_OUT, 16'h0004);
    check_eq("dir_both_r", R_OUT, 16'h0004);

    // Short frame, then good frames: error (when built in) must stick.
    frame(13'($urandom), 10, 1'b1, 1'b0, 1'b0);
    frame(13'($urandom), 16, 1'b1, 1'b0, 1'b0);
    frame(13'($urandom), 16, 1'b0, 1'b1, 1'b0);
    check_eq("err_sticky", FRAME_ERR, exp_ferr());

    // Reset in the middle of a frame, then a full frame.
    for (int k = 0; k < 8; k++) send_bit(1'($urandom_range(0, 1)));
    reset_pulse();
    check_eq("err_cleared", FRAME_ERR, 1'b0);
    frame({3'd2, 10'h3FF}, 16, 1'b0, 1'b1, 1'b0);
    check_eq("dir_after_reset", R_OUT, 16'h03FE);

    // Partial frame right after reset: missing bits read as zero.
    reset_pulse();
    frame(13'd0, 9, 1'b1, 1'b0, 1'b0);

    // Randomized frames: length, channel mix, coincident final bit, resets.
    for (int it = 0; it < 40; it++) begin
      if (it % 13 == 12) reset_pulse();
      nb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(8, 12)) : int'($urandom_range(13, 20));
      l  = 1'($urandom_range(0, 1));
      r  = 1'($urandom_range(0, 1));
      if (!l && !r) l = 1'b1;
      frame(13'($urandom), nb, l, r, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
